// File: rtl/stat_pkg.sv
// Shared types and sizing for the statistics finisher.
package stat_pkg;

    localparam int W         = 64;
    localparam int CW        = 32;
    localparam int DIV_STEPS = 64;
    localparam int MUL_STEPS = 64;

    typedef enum logic [2:0] {
        IDLE,
        DIV_MEAN,
        DIV_SQ,
        SQUARE,
        FINAL
    } stat_state_t;

endpackage

// File: rtl/stat_finalize_seq_udiv.sv
// W-bit restoring divider, one quotient bit per step, MSB first.
module seq_udiv
    import stat_pkg::*;
(
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient
);

    logic [W:0]   rem;
    logic [W:0]   rem_sh;
    logic [W:0]   rem_next;
    logic [W-1:0] quo;
    logic [W-1:0] dvsr;

    // quo starts as the dividend; its MSB is shifted into rem each step while
    // the new quotient bit enters at the LSB. quotient is the value quo takes
    // at the end of the current step, so the caller can capture the final
    // result on the same edge that performs the last iteration.
    always_comb begin
        rem_sh   = {rem[W-1:0], quo[W-1]};
        rem_next = rem_sh;
        quotient = {quo[W-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvsr}) begin
            rem_next = rem_sh - {1'b0, dvsr};
            quotient = {quo[W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rem  <= '0;
            quo  <= '0;
            dvsr <= '0;
        end else if (load) begin
            rem  <= '0;
            quo  <= dividend;
            dvsr <= divisor;
        end else if (step) begin
            rem  <= rem_next;
            quo  <= quotient;
        end
    end

endmodule

// File: rtl/stat_finalize.sv
// Integer mean and population variance from merged sum / sum of squares / count.
//
// state    | meaning
// IDLE     | waiting for start
// DIV_MEAN | 64 divider steps of sum / N
// DIV_SQ   | 64 divider steps of sumsq / N
// SQUARE   | 64 shift-add steps of mean * mean
// FINAL    | publish results, pulse done
module stat_finalize
    import stat_pkg::*;
(
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [W-1:0]  sum_in,
    input  logic [W-1:0]  sum_square_in,
    input  logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  mean,
    output logic [W-1:0]  variance,
    output logic          div_zero
);

    localparam logic [6:0] DIV_LAST = 7'(DIV_STEPS - 1);
    localparam logic [6:0] MUL_LAST = 7'(MUL_STEPS - 1);

    stat_state_t    state;
    logic [6:0]     cnt;
    logic [W-1:0]   sumsq_reg;
    logic [CW-1:0]  n_reg;
    logic [W-1:0]   mean_int;
    logic [W-1:0]   q2;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_next;

    logic           div_load;
    logic           div_step;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic [W-1:0]   div_quotient;

    // The divider is loaded with sum/N on the accepting edge and reloaded with
    // sumsq/N on the edge that retires the last mean iteration.
    always_comb begin
        div_load     = 1'b0;
        div_step     = (state == DIV_MEAN) || (state == DIV_SQ);
        div_dividend = sumsq_reg;
        div_divisor  = {{(W-CW){1'b0}}, n_reg};
        if (state == IDLE) begin
            div_load     = start;
            div_dividend = sum_in;
            div_divisor  = {{(W-CW){1'b0}}, count};
        end else if (state == DIV_MEAN && cnt == 7'd0) begin
            div_load     = 1'b1;
        end
    end

    seq_udiv u_div (
        .clk      (clk),
        .nreset   (nreset),
        .load     (div_load),
        .step     (div_step),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient)
    );

    assign prod_next = mplier[0] ? (prod + mcand) : prod;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            cnt       <= '0;
            sumsq_reg <= '0;
            n_reg     <= '0;
            mean_int  <= '0;
            q2        <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mean      <= '0;
            variance  <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sumsq_reg <= sum_square_in;
                        n_reg     <= count;
                        busy      <= 1'b1;
                        div_zero  <= 1'b0;
                        cnt       <= DIV_LAST;
                        state     <= (count == '0) ? FINAL : DIV_MEAN;
                    end
                end
                DIV_MEAN: begin
                    if (cnt == 7'd0) begin
                        mean_int <= div_quotient;
                        cnt      <= DIV_LAST;
                        state    <= DIV_SQ;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                DIV_SQ: begin
                    if (cnt == 7'd0) begin
                        q2     <= div_quotient;
                        mcand  <= {{W{1'b0}}, mean_int};
                        mplier <= mean_int;
                        prod   <= '0;
                        cnt    <= MUL_LAST;
                        state  <= SQUARE;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                SQUARE: begin
                    prod   <= prod_next;
                    mcand  <= {mcand[2*W-2:0], 1'b0};
                    mplier <= {1'b0, mplier[W-1:1]};
                    if (cnt == 7'd0) begin
                        state <= FINAL;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                FINAL: begin
                    if (n_reg == '0) begin
                        mean     <= '1;
                        variance <= '0;
                        div_zero <= 1'b1;
                    end else begin
                        mean <= mean_int;
                        // sumsq/N below mean^2 only happens with inconsistent inputs
                        if (prod[2*W-1:W] != '0 || prod[W-1:0] > q2) begin
                            variance <= '0;
                        end else begin
                            variance <= q2 - prod[W-1:0];
                        end
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
